// File: rtl/udp_ip_tx_hdr_calc.sv
// UDP/IPv4 TX header calculator: forwards payload bytes to the MAC TX FIFO and derives the length/checksum fields.
// Optional macro UDP_CHECKSUM_EN enables the UDP payload checksum; without it the UDP checksum field is 0x0000.
module udp_ip_tx_hdr_calc #(
  parameter int unsigned MAX_PAYLOAD = 1472,
  parameter logic [7:0]  IP_TTL      = 8'd64,
  parameter logic [15:0] IP_ID       = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] cfg_src_ip,
  input  logic [31:0] cfg_dst_ip,
  input  logic [15:0] cfg_src_port,
  input  logic [15:0] cfg_dst_port,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_trdy,
  output logic [7:0]  m_tx_axis_tdata,
  output logic        m_tx_axis_tvalid,
  output logic        m_tx_axis_tlast,
  input  logic        m_tx_axis_trdy,
  output logic        m_hdr_tvalid,
  output logic [15:0] m_udp_hdr_length,
  output logic [15:0] m_udp_hdr_checksum,
  output logic [15:0] m_ip_hdr_length,
  output logic [15:0] m_ip_hdr_checksum,
  output logic        m_hdr_oversize
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STREAM = 3'd1,
    CALC0  = 3'd2,
    CALC1  = 3'd3,
    CALC2  = 3'd4,
    EMIT   = 3'd5
  } state_t;

  localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

  state_t      state_r;
  logic [15:0] len_r;
  logic [31:0] src_ip_r;
  logic [31:0] dst_ip_r;
  logic        pass_s;
  logic        accept_s;
  logic [15:0] udp_len_s;
  logic [15:0] ip_len_s;
  logic [15:0] udp_csum_s;
  logic [31:0] ip_sum_s;
  logic [15:0] ip_csum_s;

  // End-around-carry fold of a 32-bit one's-complement sum down to 16 bits.
  function automatic logic [15:0] fold16(input logic [31:0] v);
    logic [31:0] t;
    t = {16'h0000, v[31:16]} + {16'h0000, v[15:0]};
    t = {16'h0000, t[31:16]} + {16'h0000, t[15:0]};
    return t[15:0];
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

  // Payload path is open only while a packet is being collected.
  always_comb begin
    pass_s = 1'b0;
    if ((state_r == IDLE) || (state_r == STREAM)) begin
      pass_s = 1'b1;
    end else begin
      pass_s = 1'b0;
    end
  end

  assign s_axis_trdy      = pass_s & m_tx_axis_trdy;
  assign m_tx_axis_tvalid = pass_s & s_axis_tvalid;
  assign m_tx_axis_tdata  = s_axis_tdata;
  assign m_tx_axis_tlast  = s_axis_tlast;
  assign accept_s         = s_axis_tvalid & s_axis_trdy;

  assign udp_len_s = len_r + 16'd8;
  assign ip_len_s  = len_r + 16'd28;

  // IPv4 header sum over the fixed fields, lengths and addresses.
  always_comb begin
    ip_sum_s  = 32'h0000_4500 + ext16(ip_len_s) + ext16(IP_ID) + 32'h0000_4000
              + ext16({IP_TTL, 8'h11})
              + ext16(src_ip_r[31:16]) + ext16(src_ip_r[15:0])
              + ext16(dst_ip_r[31:16]) + ext16(dst_ip_r[15:0]);
    ip_csum_s = ~fold16(ip_sum_s);
  end

`ifdef UDP_CHECKSUM_EN
  logic [31:0] acc_r;
  logic        odd_r;
  logic [15:0] src_port_r;
  logic [15:0] dst_port_r;
  logic [15:0] udp_fold_r;
  logic [31:0] byte_word_s;
  logic [31:0] pseudo_s;
  logic [15:0] udp_inv_s;

  // Byte placement within its 16-bit word plus pseudo-header/UDP-header terms.
  always_comb begin
    byte_word_s = 32'h0000_0000;
    if (odd_r) begin
      byte_word_s = {24'h00_0000, s_axis_tdata};
    end else begin
      byte_word_s = {16'h0000, s_axis_tdata, 8'h00};
    end
    pseudo_s  = ext16(src_ip_r[31:16]) + ext16(src_ip_r[15:0])
              + ext16(dst_ip_r[31:16]) + ext16(dst_ip_r[15:0])
              + 32'h0000_0011 + ext16(udp_len_s)
              + ext16(src_port_r) + ext16(dst_port_r) + ext16(udp_len_s);
    udp_inv_s = ~udp_fold_r;
    if (udp_inv_s == 16'h0000) begin
      udp_csum_s = 16'hFFFF;
    end else begin
      udp_csum_s = udp_inv_s;
    end
  end

  // Payload sum accumulation and UDP checksum folding.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      acc_r      <= 32'h0000_0000;
      odd_r      <= 1'b0;
      src_port_r <= 16'h0000;
      dst_port_r <= 16'h0000;
      udp_fold_r <= 16'h0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            acc_r      <= {16'h0000, s_axis_tdata, 8'h00};
            odd_r      <= 1'b1;
            src_port_r <= cfg_src_port;
            dst_port_r <= cfg_dst_port;
          end
        end
        STREAM: begin
          if (accept_s) begin
            acc_r <= acc_r + byte_word_s;
            odd_r <= ~odd_r;
          end
        end
        CALC0:   acc_r <= acc_r + pseudo_s;
        CALC1:   udp_fold_r <= fold16(acc_r);
        default: acc_r <= acc_r;
      endcase
    end
  end
`else
  logic unused_ports_s;
  assign unused_ports_s = ^{cfg_src_port, cfg_dst_port};
  assign udp_csum_s     = 16'h0000;
`endif

  // Packet FSM: length count, address capture and registered header outputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_r            <= IDLE;
      len_r              <= 16'h0000;
      src_ip_r           <= 32'h0000_0000;
      dst_ip_r           <= 32'h0000_0000;
      m_hdr_tvalid       <= 1'b0;
      m_udp_hdr_length   <= 16'h0000;
      m_udp_hdr_checksum <= 16'h0000;
      m_ip_hdr_length    <= 16'h0000;
      m_ip_hdr_checksum  <= 16'h0000;
      m_hdr_oversize     <= 1'b0;
    end else begin
      m_hdr_tvalid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            src_ip_r <= cfg_src_ip;
            dst_ip_r <= cfg_dst_ip;
            len_r    <= 16'd1;
            state_r  <= s_axis_tlast ? CALC0 : STREAM;
          end
        end
        STREAM: begin
          if (accept_s) begin
            if (len_r != 16'hFFFF) begin
              len_r <= len_r + 16'd1;
            end
            if (s_axis_tlast) begin
              state_r <= CALC0;
            end
          end
        end
        CALC0: state_r <= CALC1;
        CALC1: state_r <= CALC2;
        CALC2: begin
          // Header outputs change only here so they stay stable from one EMIT to the next.
          m_udp_hdr_length   <= udp_len_s;
          m_udp_hdr_checksum <= udp_csum_s;
          m_ip_hdr_length    <= ip_len_s;
          m_ip_hdr_checksum  <= ip_csum_s;
          m_hdr_oversize     <= (len_r > MAX_LEN);
          m_hdr_tvalid       <= 1'b1;
          state_r            <= EMIT;
        end
        EMIT:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_ip_tx_hdr_calc.sv
// Scoreboard bench for udp_ip_tx_hdr_calc: randomized payloads and FIFO stalls against a plain-arithmetic reference.
module tb_udp_ip_tx_hdr_calc;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic [31:0] cfg_src_ip, cfg_dst_ip;
  logic [15:0] cfg_src_port, cfg_dst_port;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_trdy;
  logic [7:0]  m_tx_axis_tdata;
  logic        m_tx_axis_tvalid, m_tx_axis_tlast, m_tx_axis_trdy;
  logic        m_hdr_tvalid, m_hdr_oversize;
  logic [15:0] m_udp_hdr_length, m_udp_hdr_checksum, m_ip_hdr_length, m_ip_hdr_checksum;

  typedef struct {
    logic [15:0] ulen;
    logic [15:0] ucsum;
    logic [15:0] ilen;
    logic [15:0] icsum;
    logic        ovs;
  } hdr_t;

  hdr_t        exp_hdr_q[$];
  logic [8:0]  exp_byte_q[$];
  logic [7:0]  pay[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_cyc = 0;
  bit          stall_en = 1'b0;

  udp_ip_tx_hdr_calc dut (
    .i_clk(clk), .i_reset_n(i_reset_n),
    .cfg_src_ip(cfg_src_ip), .cfg_dst_ip(cfg_dst_ip),
    .cfg_src_port(cfg_src_port), .cfg_dst_port(cfg_dst_port),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_trdy(s_axis_trdy),
    .m_tx_axis_tdata(m_tx_axis_tdata), .m_tx_axis_tvalid(m_tx_axis_tvalid),
    .m_tx_axis_tlast(m_tx_axis_tlast), .m_tx_axis_trdy(m_tx_axis_trdy),
    .m_hdr_tvalid(m_hdr_tvalid), .m_udp_hdr_length(m_udp_hdr_length),
    .m_udp_hdr_checksum(m_udp_hdr_checksum), .m_ip_hdr_length(m_ip_hdr_length),
    .m_ip_hdr_checksum(m_ip_hdr_checksum), .m_hdr_oversize(m_hdr_oversize)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic int unsigned ones_fold(input int unsigned s);
    int unsigned t;
    t = s;
    while (t > 32'hFFFF) t = (t & 32'hFFFF) + (t >> 16);
    return t;
  endfunction

  // Reference header from the current cfg_* and the pay[] bytes.
  function automatic hdr_t ref_hdr();
    hdr_t        h;
    int unsigned n, len, ulen, ilen, s;
    n    = pay.size();
    len  = (n > 65535) ? 65535 : n;
    ulen = (len + 8) & 32'hFFFF;
    ilen = (len + 28) & 32'hFFFF;
    s = (cfg_src_ip >> 16) + (cfg_src_ip & 32'hFFFF) + (cfg_dst_ip >> 16) + (cfg_dst_ip & 32'hFFFF)
      + 17 + ulen + 32'(cfg_src_port) + 32'(cfg_dst_port) + ulen;
    for (int i = 0; i < int'(n); i++) begin
      if (i % 2 == 0) s = s + 32'({pay[i], 8'h00});
      else            s = s + 32'(pay[i]);
    end
    s = ones_fold(s);
    h.ucsum = ~s[15:0];
    if (h.ucsum == 16'h0000) h.ucsum = 16'hFFFF;
`ifndef UDP_CHECKSUM_EN
    h.ucsum = 16'h0000;
`endif
    s = 32'h4500 + ilen + 0 + 32'h4000 + 32'h4011
      + (cfg_src_ip >> 16) + (cfg_src_ip & 32'hFFFF) + (cfg_dst_ip >> 16) + (cfg_dst_ip & 32'hFFFF);
    s = ones_fold(s);
    h.icsum = ~s[15:0];
    h.ulen  = ulen[15:0];
    h.ilen  = ilen[15:0];
    h.ovs   = (len > 1472);
    return h;
  endfunction

  task automatic set_cfg(input logic [31:0] sip, input logic [31:0] dip, input logic [15:0] sp, input logic [15:0] dp);
    cfg_src_ip = sip; cfg_dst_ip = dip; cfg_src_port = sp; cfg_dst_port = dp;
  endtask

  task automatic fill_random(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    s_axis_tdata = d; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    for (int w = 0; w < 400 && !ok; w++) begin
      @(negedge clk);
      if (s_axis_trdy) ok = 1'b1;
    end
    if (ok && l) last_cyc = cyc;
    chk("beat_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic send_pkt(input bit complete);
    int   n;
    logic l;
    n = pay.size();
    if (complete) exp_hdr_q.push_back(ref_hdr());
    for (int i = 0; i < n; i++) begin
      l = complete && (i == n - 1);
      exp_byte_q.push_back({l, pay[i]});
      send_beat(pay[i], l);
      // cfg must have been captured on the first beat; scramble it afterwards.
      if (i == 0) set_cfg($urandom, $urandom, 16'($urandom), 16'($urandom));
    end
  endtask

  task automatic drain(input string nm);
    for (int w = 0; w < 200 && (exp_hdr_q.size() != 0 || exp_byte_q.size() != 0); w++) @(negedge clk);
    chk(nm, 32'(exp_hdr_q.size() + exp_byte_q.size()), 32'd0);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_hdr_tvalid"}, 32'(m_hdr_tvalid), 32'd0);
    chk({nm, "_udp_len"}, 32'(m_udp_hdr_length), 32'd0);
    chk({nm, "_udp_csum"}, 32'(m_udp_hdr_checksum), 32'd0);
    chk({nm, "_ip_len"}, 32'(m_ip_hdr_length), 32'd0);
    chk({nm, "_ip_csum"}, 32'(m_ip_hdr_checksum), 32'd0);
    chk({nm, "_oversize"}, 32'(m_hdr_oversize), 32'd0);
  endtask

  initial begin
    m_tx_axis_trdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_tx_axis_trdy = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: FIFO-side bytes and header strobes against the scoreboard queues.
  initial begin
    logic [8:0] eb;
    hdr_t       h;
    forever begin
      @(negedge clk);
      if (i_reset_n && m_tx_axis_tvalid && m_tx_axis_trdy) begin
        chk("fifo_expected", 32'(exp_byte_q.size() != 0), 32'd1);
        if (exp_byte_q.size() != 0) begin
          eb = exp_byte_q.pop_front();
          chk("fifo_data", 32'(m_tx_axis_tdata), 32'(eb[7:0]));
          chk("fifo_last", 32'(m_tx_axis_tlast), 32'(eb[8]));
        end
      end
      if (m_hdr_tvalid) begin
        chk("hdr_expected", 32'(exp_hdr_q.size() != 0), 32'd1);
        if (exp_hdr_q.size() != 0) begin
          h = exp_hdr_q.pop_front();
          chk("udp_len", 32'(m_udp_hdr_length), 32'(h.ulen));
          chk("udp_csum", 32'(m_udp_hdr_checksum), 32'(h.ucsum));
          chk("ip_len", 32'(m_ip_hdr_length), 32'(h.ilen));
          chk("ip_csum", 32'(m_ip_hdr_checksum), 32'(h.icsum));
          chk("oversize", 32'(m_hdr_oversize), 32'(h.ovs));
          chk("hdr_latency", 32'(cyc - last_cyc), 32'd4);
          chk("trdy_in_emit", 32'(s_axis_trdy), 32'd0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset_n = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = 8'h00;
    set_cfg(32'h0, 32'h0, 16'h0, 16'h0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    i_reset_n = 1'b1;

    set_cfg(32'hC0A8_0001, 32'hC0A8_00C7, 16'($urandom), 16'($urandom));
    fill_random(87);
    send_pkt(1'b1);

    set_cfg(32'hC0A8_0001, 32'hC0A8_00C7, 16'd1234, 16'd5678);
    pay.delete(); pay.push_back(8'h00); pay.push_back(8'h00);
    send_pkt(1'b1);

    set_cfg(32'hC0A8_0001, 32'hC0A8_00C7, 16'd1234, 16'd5678);
    pay.delete(); pay.push_back(8'hAB);
    send_pkt(1'b1);

    stall_en = 1'b1;
    set_cfg($urandom, $urandom, 16'($urandom), 16'($urandom));
    fill_random(1472);
    send_pkt(1'b1);
    set_cfg($urandom, $urandom, 16'($urandom), 16'($urandom));
    fill_random(1473);
    send_pkt(1'b1);

    for (int p = 0; p < 8; p++) begin
      set_cfg($urandom, $urandom, 16'($urandom), 16'($urandom));
      fill_random($urandom_range(1, 64));
      send_pkt(1'b1);
    end
    drain("drain_before_abort");

    set_cfg($urandom, $urandom, 16'($urandom), 16'($urandom));
    fill_random(10);
    send_pkt(1'b0);
    @(posedge clk); #1;
    i_reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("mid_reset");
    @(posedge clk); #1;
    i_reset_n = 1'b1;
    stall_en = 1'b0;

    set_cfg(32'hC0A8_0001, 32'hC0A8_00C7, 16'd1234, 16'd5678);
    pay.delete(); pay.push_back(8'h00); pay.push_back(8'h00);
    send_pkt(1'b1);
    drain("drain_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
